mig_ui_model: RTL and testbench

Synthesizable responder for the MIG native user interface. It plays the memory-controller side of the MIG port: it accepts commands and write data from an application, stores them in an on-chip block-RAM backing store, returns read data in order after a fixed latency, and services refresh/ZQ requests with acknowledges. It stands in for the MIG core in simulation and in fabric-only builds of the HDMI demo, so APP-side logic runs unchanged with no DDR present.

---
 rtl/mig_ui_model_if.sv | 42 ++++
 rtl/mig_ui_model.sv | 229 ++++++++++++++++++++++
 tb/tb_mig_ui_model.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_ui_model_if.sv
// MIG native user-interface bundle shared by the application logic (master)
// and the memory-controller stand-in (slave).
interface mig_ui_model_if #(
    parameter int DW = 128,
    parameter int AW = 30
);
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic            app_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;
    logic            app_rd_data_end;
    logic            app_ref_req;
    logic            app_zq_req;
    logic            app_ref_ack;
    logic            app_zq_ack;
    logic            init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_ref_req, app_zq_req,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  app_ref_ack, app_zq_ack, init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_ref_req, app_zq_req,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output app_ref_ack, app_zq_ack, init_calib_complete
    );
endinterface

// File: rtl/mig_ui_model.sv
// Stand-in for the MIG memory controller: queues app commands and write data,
// serves them from an on-chip block RAM, and acknowledges refresh/ZQ requests.
module mig_ui_model #(
    parameter int DW           = 128,
    parameter int AW           = 30,
    parameter int DEPTH_LOG2   = 10,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LAT       = 4,
    parameter int MAINT_CYCLES = 8,
    parameter int QDEPTH       = 4
) (
    input logic           clk,
    input logic           rst,
    mig_ui_model_if.slave ui
);
    localparam int MW   = DW / 8;
    localparam int QPW  = $clog2(QDEPTH);
    localparam int CNTW = QPW + 1;
    localparam int CW   = $clog2(CALIB_CYCLES + 1);
    localparam int MCW  = $clog2(MAINT_CYCLES + 1);
    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {ST_CALIB, ST_RUN, ST_REF, ST_ZQ} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  calib_cnt, calib_cnt_next;
    logic [MCW-1:0] maint_cnt, maint_cnt_next;
    logic           calib_done, calib_done_next;
    logic           ref_pend, ref_pend_next;
    logic           zq_pend, zq_pend_next;
    logic           ref_start, zq_start;
    logic           ref_ack, zq_ack;

    logic [2:0]            cq_cmd [QDEPTH];
    logic [DEPTH_LOG2-1:0] cq_idx [QDEPTH];
    logic [QPW-1:0]        cq_wp, cq_rp;
    logic [CNTW-1:0]       cq_cnt, cq_cnt_next;
    logic                  cq_push, cq_pop, cmd_rdy;

    logic [DW-1:0]   dq_data [QDEPTH];
    logic [MW-1:0]   dq_mask [QDEPTH];
    logic [QPW-1:0]  dq_wp, dq_rp;
    logic [CNTW-1:0] dq_cnt, dq_cnt_next;
    logic            dq_push, dq_pop, data_rdy;

    logic                  exec_en, ram_we, ram_re;
    logic [2:0]            head_cmd;
    logic [DEPTH_LOG2-1:0] head_idx;
    logic [DW-1:0]         head_data;
    logic [MW-1:0]         head_mask;
    logic [DW-1:0]         mem [2**DEPTH_LOG2];
    logic [DW-1:0]         ram_q;
    logic [DW-1:0]         rd_pipe [RD_LAT-1];
    logic [RD_LAT-1:0]     rd_vld;
    logic                  unused;

    assign unused = ^{ui.app_wdf_end, ui.app_addr[AW-1:DEPTH_LOG2+3], ui.app_addr[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CALIB;
            calib_cnt  <= '0;
            maint_cnt  <= '0;
            calib_done <= 1'b0;
            ref_pend   <= 1'b0;
            zq_pend    <= 1'b0;
        end else begin
            state      <= state_next;
            calib_cnt  <= calib_cnt_next;
            maint_cnt  <= maint_cnt_next;
            calib_done <= calib_done_next;
            ref_pend   <= ref_pend_next;
            zq_pend    <= zq_pend_next;
        end
    end

    // Back-to-back maintenance goes straight from one op to the next so the
    // second ack follows the first by exactly MAINT_CYCLES.
    always_comb begin
        state_next      = state;
        calib_cnt_next  = calib_cnt;
        maint_cnt_next  = maint_cnt;
        calib_done_next = calib_done;
        ref_start       = 1'b0;
        zq_start        = 1'b0;
        ref_ack         = 1'b0;
        zq_ack          = 1'b0;
        case (state)
            ST_CALIB: begin
                if (calib_cnt == CW'(CALIB_CYCLES - 1)) begin
                    state_next      = ST_RUN;
                    calib_done_next = 1'b1;
                end else begin
                    calib_cnt_next = calib_cnt + CW'(1);
                end
            end
            ST_RUN: begin
                maint_cnt_next = '0;
                if (ref_pend) begin
                    state_next = ST_REF;
                    ref_start  = 1'b1;
                end else if (zq_pend) begin
                    state_next = ST_ZQ;
                    zq_start   = 1'b1;
                end
            end
            ST_REF, ST_ZQ: begin
                if (maint_cnt == MCW'(MAINT_CYCLES - 1)) begin
                    ref_ack        = (state == ST_REF);
                    zq_ack         = (state == ST_ZQ);
                    maint_cnt_next = '0;
                    if (ref_pend) begin
                        state_next = ST_REF;
                        ref_start  = 1'b1;
                    end else if (zq_pend) begin
                        state_next = ST_ZQ;
                        zq_start   = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    maint_cnt_next = maint_cnt + MCW'(1);
                end
            end
            default: state_next = ST_CALIB;
        endcase
        ref_pend_next = (ref_pend && !ref_start) || ui.app_ref_req;
        zq_pend_next  = (zq_pend && !zq_start) || ui.app_zq_req;
    end

    assign cq_push   = ui.app_en && cmd_rdy;
    assign dq_push   = ui.app_wdf_wren && data_rdy;
    assign head_cmd  = cq_cmd[cq_rp];
    assign head_idx  = cq_idx[cq_rp];
    assign head_data = dq_data[dq_rp];
    assign head_mask = dq_mask[dq_rp];
    assign exec_en   = !rst && (state == ST_RUN) && !ref_pend && !zq_pend;

    // A write at the head waits for its data, which also holds back any read
    // queued behind it.
    always_comb begin
        cq_pop = 1'b0;
        dq_pop = 1'b0;
        ram_we = 1'b0;
        ram_re = 1'b0;
        if (exec_en && (cq_cnt != '0)) begin
            case (head_cmd)
                CMD_READ: begin
                    ram_re = 1'b1;
                    cq_pop = 1'b1;
                end
                CMD_WRITE: begin
                    if (dq_cnt != '0) begin
                        ram_we = 1'b1;
                        cq_pop = 1'b1;
                        dq_pop = 1'b1;
                    end
                end
                default: cq_pop = 1'b1;
            endcase
        end
        cq_cnt_next = cq_cnt + CNTW'(cq_push) - CNTW'(cq_pop);
        dq_cnt_next = dq_cnt + CNTW'(dq_push) - CNTW'(dq_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cq_wp    <= '0;
            cq_rp    <= '0;
            cq_cnt   <= '0;
            dq_wp    <= '0;
            dq_rp    <= '0;
            dq_cnt   <= '0;
            cmd_rdy  <= 1'b0;
            data_rdy <= 1'b0;
        end else begin
            if (cq_push) cq_wp <= cq_wp + QPW'(1);
            if (cq_pop)  cq_rp <= cq_rp + QPW'(1);
            if (dq_push) dq_wp <= dq_wp + QPW'(1);
            if (dq_pop)  dq_rp <= dq_rp + QPW'(1);
            cq_cnt   <= cq_cnt_next;
            dq_cnt   <= dq_cnt_next;
            cmd_rdy  <= calib_done_next && (cq_cnt_next < CNTW'(QDEPTH));
            data_rdy <= calib_done_next && (dq_cnt_next < CNTW'(QDEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (cq_push) begin
            cq_cmd[cq_wp] <= ui.app_cmd;
            cq_idx[cq_wp] <= ui.app_addr[DEPTH_LOG2+2:3];
        end
        if (dq_push) begin
            dq_data[dq_wp] <= ui.app_wdf_data;
            dq_mask[dq_wp] <= ui.app_wdf_mask;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (!head_mask[b]) mem[head_idx][b*8 +: 8] <= head_data[b*8 +: 8];
            end
        end
        if (ram_re) ram_q <= mem[head_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LAT - 1; i++) rd_pipe[i] <= '0;
        end else begin
            rd_vld     <= {rd_vld[RD_LAT-2:0], ram_re};
            rd_pipe[0] <= ram_q;
            for (int i = 1; i < RD_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign ui.app_rdy             = cmd_rdy;
    assign ui.app_wdf_rdy         = data_rdy;
    assign ui.app_rd_data         = rd_pipe[RD_LAT-2];
    assign ui.app_rd_data_valid   = rd_vld[RD_LAT-1];
    assign ui.app_rd_data_end     = rd_vld[RD_LAT-1];
    assign ui.app_ref_ack         = ref_ack;
    assign ui.app_zq_ack          = zq_ack;
    assign ui.init_calib_complete = calib_done;
endmodule

// File: tb/tb_mig_ui_model.sv
// Directed bench for mig_ui_model: expected read data is queued in issue order
// and checked against every beat the model returns.
module tb_mig_ui_model;
    localparam int DW     = 128;
    localparam int AW     = 30;
    localparam int CALIB  = 64;
    localparam int RD_LAT = 4;
    localparam int MAINT  = 8;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] model [int];
    int            valid_cyc [$];
    int            ref_acks = 0;
    int            zq_acks = 0;
    int            ref_ack_cyc = -1;
    int            zq_ack_cyc = -1;

    mig_ui_model_if #(.DW(DW), .AW(AW)) bus ();

    mig_ui_model #(
        .DW(DW), .AW(AW), .DEPTH_LOG2(10), .CALIB_CYCLES(CALIB),
        .RD_LAT(RD_LAT), .MAINT_CYCLES(MAINT), .QDEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ui (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [AW-1:0] a);
        return int'(a[12:3]);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW/8; b++) if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_rd(input int k);
        return model.exists(k) ? model[k] : '0;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.app_rd_data_valid) begin
            valid_cyc.push_back(cyc);
            check_output("rd_expected", DW'(sb.size() != 0), DW'(1));
            if (sb.size() != 0) begin
                check_output("rd_data", bus.app_rd_data, sb.pop_front());
                check_output("rd_end", DW'(bus.app_rd_data_end), DW'(1));
            end
        end
        if (!rst && bus.app_ref_ack) begin
            ref_acks    <= ref_acks + 1;
            ref_ack_cyc <= cyc;
        end
        if (!rst && bus.app_zq_ack) begin
            zq_acks    <= zq_acks + 1;
            zq_ack_cyc <= cyc;
        end
    end

    // Called just after a falling edge; returns the cycle of the accepting edge.
    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, output int acc);
        bus.app_en   = 1'b1;
        bus.app_cmd  = c;
        bus.app_addr = a;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            if (bus.app_rdy) acc = cyc + 1;
            @(negedge clk);
        end
        bus.app_en = 1'b0;
        check_output("cmd_accept", DW'(acc >= 0), DW'(1));
    endtask

    task automatic send_data(input logic [DW-1:0] d, input logic [DW/8-1:0] m, output int acc);
        bus.app_wdf_wren = 1'b1;
        bus.app_wdf_end  = 1'b1;
        bus.app_wdf_data = d;
        bus.app_wdf_mask = m;
        acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            if (bus.app_wdf_rdy) acc = cyc + 1;
            @(negedge clk);
        end
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end  = 1'b0;
        check_output("wdf_accept", DW'(acc >= 0), DW'(1));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        int dacc, wacc;
        model[word_of(a)] = merge(model_rd(word_of(a)), d, m);
        send_data(d, m, dacc);
        send_cmd(CMD_WR, a, wacc);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int acc);
        sb.push_back(model_rd(word_of(a)));
        send_cmd(CMD_RD, a, acc);
    endtask

    task automatic wait_reads();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("reads_drained", DW'(sb.size()), DW'(0));
        @(negedge clk);
    endtask

    initial begin
        int r, rise, any_rdy, acc, dacc, wacc, a_edge, n_acc, stall_at, ref0, zq0, nv0, vc, lat, n;
        logic [DW-1:0] d2, d4;

        bus.app_addr     = '0;
        bus.app_cmd      = CMD_RD;
        bus.app_en       = 1'b0;
        bus.app_wdf_data = '0;
        bus.app_wdf_mask = '0;
        bus.app_wdf_wren = 1'b0;
        bus.app_wdf_end  = 1'b0;
        bus.app_ref_req  = 1'b0;
        bus.app_zq_req   = 1'b0;
        repeat (3) @(negedge clk);

        check_output("rst_app_rdy", DW'(bus.app_rdy), DW'(0));
        check_output("rst_wdf_rdy", DW'(bus.app_wdf_rdy), DW'(0));
        check_output("rst_rd_valid", DW'(bus.app_rd_data_valid), DW'(0));
        check_output("rst_rd_end", DW'(bus.app_rd_data_end), DW'(0));
        check_output("rst_ref_ack", DW'(bus.app_ref_ack), DW'(0));
        check_output("rst_zq_ack", DW'(bus.app_zq_ack), DW'(0));
        check_output("rst_calib", DW'(bus.init_calib_complete), DW'(0));
        check_output("rst_rd_data", bus.app_rd_data, DW'(0));

        // Offer a read and write data throughout calibration; neither may be taken.
        rst = 1'b0;
        r = cyc;
        bus.app_en = 1'b1;
        bus.app_addr = 30'h40;
        bus.app_wdf_wren = 1'b1;
        bus.app_wdf_data = '1;
        rise = -1;
        any_rdy = 0;
        for (int i = 0; i < 200 && rise < 0; i++) begin
            @(negedge clk);
            if (cyc >= r + CALIB - 4) begin
                bus.app_en = 1'b0;
                bus.app_wdf_wren = 1'b0;
            end
            if (bus.init_calib_complete) rise = cyc;
            else if (bus.app_rdy || bus.app_wdf_rdy) any_rdy = 1;
        end
        check_output("calib_latency", DW'(rise - r), DW'(CALIB));
        check_output("rdy_during_calib", DW'(any_rdy), DW'(0));
        check_output("app_rdy_after_calib", DW'(bus.app_rdy), DW'(1));
        check_output("wdf_rdy_after_calib", DW'(bus.app_wdf_rdy), DW'(1));

        d2 = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_write(30'h40, d2, '0);
        repeat (3) @(negedge clk);
        nv0 = valid_cyc.size();
        do_read(30'h40, acc);
        wait_reads();
        vc = (valid_cyc.size() > nv0) ? valid_cyc[nv0] : -1;
        check_output("idle_rd_latency", DW'(vc - acc), DW'(RD_LAT));

        do_write(30'h80, '1, '0);
        do_write(30'h80, '0, 16'hFFFE);
        do_read(30'h80, acc);
        wait_reads();

        send_cmd(3'b011, 30'h40, acc);
        do_read(30'h40, acc);
        wait_reads();

        // Write command first, its data three cycles later, read queued behind.
        d4 = 128'hCAFEF00D_DEADBEEF_13579BDF_2468ACE0;
        nv0 = valid_cyc.size();
        send_cmd(CMD_WR, 30'h100, wacc);
        model[word_of(30'h100)] = merge(model_rd(word_of(30'h100)), d4, '0);
        do_read(30'h100, acc);
        @(negedge clk);
        send_data(d4, '0, dacc);
        wait_reads();
        vc = (valid_cyc.size() > nv0) ? valid_cyc[nv0] : -1;
        check_output("raw_after_data", DW'(vc >= dacc + RD_LAT), DW'(1));

        for (int i = 0; i < 6; i++)
            do_write(30'h200 + 30'(i * 8), {4{32'hA5A50000 + 32'(i)}}, '0);
        repeat (4) @(negedge clk);
        ref0 = ref_acks;
        nv0 = valid_cyc.size();
        bus.app_ref_req = 1'b1;
        @(negedge clk);
        bus.app_ref_req = 1'b0;
        a_edge = cyc;
        n_acc = 0;
        stall_at = -1;
        for (int i = 0; i < 200 && n_acc < 6; i++) begin
            bus.app_en = 1'b1;
            bus.app_cmd = CMD_RD;
            bus.app_addr = 30'h200 + 30'(n_acc * 8);
            if (bus.app_rdy) begin
                sb.push_back(model_rd(word_of(bus.app_addr)));
                n_acc++;
            end else if (stall_at < 0) begin
                stall_at = n_acc;
            end
            @(negedge clk);
        end
        bus.app_en = 1'b0;
        n = 0;
        while (ref_acks == ref0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        wait_reads();
        lat = ref_ack_cyc - a_edge;
        check_output("reads_accepted", DW'(n_acc), DW'(6));
        check_output("stall_after", DW'(stall_at), DW'(4));
        check_output("ref_ack_count", DW'(ref_acks - ref0), DW'(1));
        check_output("ref_ack_latency", DW'(lat >= MAINT && lat <= MAINT + 1), DW'(1));
        vc = (valid_cyc.size() > nv0) ? valid_cyc[nv0] : -1;
        check_output("reads_after_ref", DW'(vc > ref_ack_cyc), DW'(1));

        ref0 = ref_acks;
        zq0 = zq_acks;
        bus.app_ref_req = 1'b1;
        bus.app_zq_req = 1'b1;
        @(negedge clk);
        bus.app_ref_req = 1'b0;
        bus.app_zq_req = 1'b0;
        n = 0;
        while (zq_acks == zq0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check_output("dual_ref_count", DW'(ref_acks - ref0), DW'(1));
        check_output("dual_zq_count", DW'(zq_acks - zq0), DW'(1));
        check_output("zq_after_ref", DW'(zq_ack_cyc - ref_ack_cyc), DW'(MAINT));

        do_read(30'h80, acc);
        do_read(30'h100, acc);
        wait_reads();
        check_output("total_ref_acks", DW'(ref_acks), DW'(2));
        check_output("total_zq_acks", DW'(zq_acks), DW'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
